// File: rtl/x_clk_pkg.sv
// Shared types and helpers for the BUFGMUX select sequencer.
package x_clk_pkg;

  // Sequencer state, encoded 00/01/10.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GATE   = 2'b01,
    SETTLE = 2'b10
  } state_e;

  // A wait length of zero would give no quiet time at all, so it is raised to one.
  function automatic int clamp_wait(input int cycles);
    if (cycles < 1) begin
      return 1;
    end else begin
      return cycles;
    end
  endfunction

endpackage

// File: rtl/x_bufgmux_sel_ctrl_if.sv
// Clock-switch request handshake between the clocking manager and the sequencer.
interface x_bufgmux_sel_ctrl_if;
  logic REQ_VALID;
  logic REQ_SEL;
  logic REQ_READY;

  // Requester side: presents the target select and holds it until accepted.
  modport master (
    output REQ_VALID,
    output REQ_SEL,
    input  REQ_READY
  );

  // Sequencer side.
  modport slave (
    input  REQ_VALID,
    input  REQ_SEL,
    output REQ_READY
  );
endinterface

// File: rtl/x_wait_cnt.sv
// Loadable down-counter with a zero flag. Saturates at zero, never wraps.
module x_wait_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: a load wins over a decrement; decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/x_bufgmux_sel_ctrl.sv
// Select sequencer for a BUFGMUX-style clock mux: gate CE, wait, flip S,
// wait for the new clock to settle, re-enable, report completion.
module x_bufgmux_sel_ctrl
  import x_clk_pkg::*;
#(
  parameter int GATE_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  x_bufgmux_sel_ctrl_if.slave   req,
  output logic                  S,
  output logic                  CE,
  output logic                  BUSY,
  output logic                  DONE
);

  // The counter is loaded with length-1 because the load edge itself is one wait cycle.
  localparam int               G_EFF       = clamp_wait(GATE_CYCLES);
  localparam int               T_EFF       = clamp_wait(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(G_EFF - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(T_EFF - 1);

  state_e           state_q, state_d;
  logic             s_q, s_d;
  logic             ce_q, ce_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             tgt_q, tgt_d;

  logic             cnt_load_s;
  logic [CNT_W-1:0] cnt_val_s;
  logic             cnt_dec_s;
  logic             cnt_zero_s;

  x_wait_cnt #(.CNT_W(CNT_W)) u_wait_cnt (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (cnt_load_s),
    .load_val (cnt_val_s),
    .dec      (cnt_dec_s),
    .zero     (cnt_zero_s)
  );

  // Sequencer next-state and next-output decode.
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    ce_d       = ce_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ready_d    = ready_q;
    tgt_d      = tgt_q;
    cnt_load_s = 1'b0;
    cnt_val_s  = {CNT_W{1'b0}};
    cnt_dec_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req.REQ_VALID && ready_q) begin
          if (req.REQ_SEL == s_q) begin
            // Already on the requested clock: acknowledge without touching S/CE.
            done_d = 1'b1;
          end else begin
            tgt_d      = req.REQ_SEL;
            ce_d       = 1'b0;
            ready_d    = 1'b0;
            busy_d     = 1'b1;
            cnt_load_s = 1'b1;
            cnt_val_s  = GATE_LOAD;
            state_d    = GATE;
          end
        end else begin
          state_d = IDLE;
        end
      end

      GATE: begin
        if (cnt_zero_s) begin
          s_d        = tgt_q;
          cnt_load_s = 1'b1;
          cnt_val_s  = SETTLE_LOAD;
          state_d    = SETTLE;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end

      SETTLE: begin
        if (cnt_zero_s) begin
          ce_d    = 1'b1;
          done_d  = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end

      default: begin
        // Unreachable encoding: fall back to a safe, enabled idle.
        ce_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      ce_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      tgt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      ce_q    <= ce_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      tgt_q   <= tgt_d;
    end
  end

  assign S             = s_q;
  assign CE            = ce_q;
  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign req.REQ_READY = ready_q;

endmodule
